// File: rtl/traffic_light_controller.sv
// Two-road intersection phase sequencer.
// Main road rests on green; the side road is served only on demand (latched
// request from the debounced vehicle sensor). All phase timing counts tick_en
// strobes. Lamp outputs are one-hot {red, yellow, green} and fully registered.
// Optional feature macro: FLASH_MODE_EN. It adds the flash_req input and the
// FLASH phase, which blinks main yellow and side red.
module traffic_light_controller #(
  parameter int unsigned MAIN_MIN_GREEN = 20,
  parameter int unsigned SIDE_MIN_GREEN = 6,
  parameter int unsigned SIDE_MAX_GREEN = 15,
  parameter int unsigned YELLOW_TIME    = 4,
  parameter int unsigned ALL_RED_TIME   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       vehicle_detected,
`ifdef FLASH_MODE_EN
  input  logic       flash_req,
`endif
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic [2:0] state_out,
  output logic       req_pending
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5,
    FLASH       = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Last timer value of each phase (timer counts 0 .. duration-1).
  localparam logic [7:0] MAIN_MIN_LAST = 8'(MAIN_MIN_GREEN - 1);
  localparam logic [7:0] SIDE_MIN_LAST = 8'(SIDE_MIN_GREEN - 1);
  localparam logic [7:0] SIDE_MAX_LAST = 8'(SIDE_MAX_GREEN - 1);
  localparam logic [7:0] YELLOW_LAST   = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] ALL_RED_LAST  = 8'(ALL_RED_TIME - 1);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       req_q, req_d;
  logic       blink_q, blink_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_d;

  logic       flash_w;
  logic       phase_done;
  state_t     phase_next;

`ifdef FLASH_MODE_EN
  assign flash_w = flash_req;
`else
  assign flash_w = 1'b0;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Phase exit condition and successor for the normal timed sequence.
  always_comb begin
    phase_done = 1'b0;
    phase_next = state_q;
    case (state_q)
      MAIN_GREEN: begin
        phase_done = (timer_q >= MAIN_MIN_LAST) && req_q;
        phase_next = MAIN_YELLOW;
      end
      MAIN_YELLOW: begin
        phase_done = (timer_q == YELLOW_LAST);
        phase_next = ALL_RED_1;
      end
      ALL_RED_1: begin
        phase_done = (timer_q == ALL_RED_LAST);
        phase_next = SIDE_GREEN;
      end
      SIDE_GREEN: begin
        // Minimum green always honoured; then leave when the road empties
        // or when the ceiling is reached with traffic still present.
        phase_done = (timer_q >= SIDE_MIN_LAST) &&
                     (!vehicle_detected || (timer_q == SIDE_MAX_LAST));
        phase_next = SIDE_YELLOW;
      end
      SIDE_YELLOW: begin
        phase_done = (timer_q == YELLOW_LAST);
        phase_next = ALL_RED_2;
      end
      ALL_RED_2: begin
        phase_done = (timer_q == ALL_RED_LAST);
        phase_next = MAIN_GREEN;
      end
      default: begin
        phase_done = 1'b0;
        phase_next = state_q;
      end
    endcase
  end

  // Next state, timer, blink, request latch and lamp decode.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    blink_d = blink_q;

    if (flash_w && (state_q != FLASH)) begin
      // Flash request overrides the sequence immediately, tick or not.
      state_d = FLASH;
      timer_d = 8'd0;
      blink_d = 1'b1;
    end else if (state_q == FLASH) begin
      if (!flash_w) begin
        state_d = ALL_RED_2;
        timer_d = 8'd0;
      end else if (tick_en) begin
        blink_d = ~blink_q;
        timer_d = sat_inc(timer_q);
      end
    end else if (tick_en) begin
      if (phase_done) begin
        state_d = phase_next;
        timer_d = 8'd0;
      end else begin
        timer_d = sat_inc(timer_q);
      end
    end

    // Entering side green consumes the request; that clear beats a new set.
    if ((state_d == SIDE_GREEN) && (state_q != SIDE_GREEN)) begin
      req_d = 1'b0;
    end else if (vehicle_detected && (state_q != SIDE_GREEN)) begin
      req_d = 1'b1;
    end else begin
      req_d = req_q;
    end

    // Lamps are decoded from the next state so they register with it.
    case (state_d)
      MAIN_GREEN:  begin main_d = LAMP_GRN; side_d = LAMP_RED; end
      MAIN_YELLOW: begin main_d = LAMP_YEL; side_d = LAMP_RED; end
      SIDE_GREEN:  begin main_d = LAMP_RED; side_d = LAMP_GRN; end
      SIDE_YELLOW: begin main_d = LAMP_RED; side_d = LAMP_YEL; end
      FLASH: begin
        main_d = {1'b0, blink_d, 1'b0};
        side_d = {blink_d, 2'b00};
      end
      default:     begin main_d = LAMP_RED; side_d = LAMP_RED; end
    endcase
  end

  // State and output registers; reset lands in all-red clearance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALL_RED_2;
      timer_q <= 8'd0;
      req_q   <= 1'b0;
      blink_q <= 1'b0;
      main_q  <= LAMP_RED;
      side_q  <= LAMP_RED;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      blink_q <= blink_d;
      main_q  <= main_d;
      side_q  <= side_d;
    end
  end

  assign main_lights = main_q;
  assign side_lights = side_q;
  assign state_out   = state_q;
  assign req_pending = req_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench for traffic_light_controller: a phase-duration model
// queues the expected outputs for each driven cycle and they are compared
// after the clock edge; directed phase-length and async-reset checks added.
module tb_traffic_light_controller;

  localparam int MAIN_MIN = 20;
  localparam int SIDE_MIN = 6;
  localparam int SIDE_MAX = 15;
  localparam int YEL      = 4;
  localparam int ARED     = 2;

  logic       clk;
  logic       rst_n;
  logic       tick_en;
  logic       vehicle_detected;
  logic       flash_r;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic [2:0] state_out;
  logic       req_pending;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] ml;
    logic [2:0] sl;
    logic       rq;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fails  = 0;
  int occ[8];

  int m_state, m_cnt, m_req, m_blink;

  traffic_light_controller #(
    .MAIN_MIN_GREEN(MAIN_MIN),
    .SIDE_MIN_GREEN(SIDE_MIN),
    .SIDE_MAX_GREEN(SIDE_MAX),
    .YELLOW_TIME(YEL),
    .ALL_RED_TIME(ARED)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick_en(tick_en),
    .vehicle_detected(vehicle_detected),
`ifdef FLASH_MODE_EN
    .flash_req(flash_r),
`endif
    .main_lights(main_lights),
    .side_lights(side_lights),
    .state_out(state_out),
    .req_pending(req_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fails++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [2:0] lamp_main(input int s, input int b);
    case (s)
      0: return 3'b001;
      1: return 3'b010;
      6: return {1'b0, b[0], 1'b0};
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] lamp_side(input int s, input int b);
    case (s)
      3: return 3'b001;
      4: return 3'b010;
      6: return {b[0], 2'b00};
      default: return 3'b100;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 5; m_cnt = 0; m_req = 0; m_blink = 0;
  endtask

  // Reference: m_cnt is the number of ticks already spent in the phase.
  task automatic model_step(input logic tick, input logic veh, input logic fl);
    int prev, nxt, ncnt, nbl, elapsed;
    bit leave;
    prev = m_state; nxt = m_state; ncnt = m_cnt; nbl = m_blink;
    elapsed = m_cnt + 1;
    if (fl && m_state != 6) begin
      nxt = 6; ncnt = 0; nbl = 1;
    end else if (m_state == 6) begin
      if (!fl) begin
        nxt = 5; ncnt = 0;
      end else if (tick) begin
        nbl = 1 - m_blink;
        ncnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end else if (tick) begin
      leave = 0;
      case (m_state)
        0: leave = (elapsed >= MAIN_MIN) && (m_req == 1);
        1: leave = (elapsed == YEL);
        2: leave = (elapsed == ARED);
        3: leave = (elapsed >= SIDE_MIN) && (!veh || elapsed == SIDE_MAX);
        4: leave = (elapsed == YEL);
        5: leave = (elapsed == ARED);
        default: leave = 0;
      endcase
      if (leave) begin
        nxt = (m_state == 5) ? 0 : m_state + 1;
        ncnt = 0;
      end else begin
        ncnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
    if (prev != 3 && nxt == 3) m_req = 0;
    else if (veh && prev != 3) m_req = 1;
    m_state = nxt; m_cnt = ncnt; m_blink = nbl;
  endtask

  // Drive one cycle of stimulus, queue the model's expectation, then
  // compare the DUT outputs just after the edge.
  task automatic step(input logic tick, input logic veh, input logic fl);
    exp_t e;
    tick_en = tick; vehicle_detected = veh; flash_r = fl;
    model_step(tick, veh, fl);
    e.st = 3'(m_state);
    e.ml = lamp_main(m_state, m_blink);
    e.sl = lamp_side(m_state, m_blink);
    e.rq = m_req[0];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("state", int'(state_out), int'(e.st));
    check("main", int'(main_lights), int'(e.ml));
    check("side", int'(side_lights), int'(e.sl));
    check("req", int'(req_pending), int'(e.rq));
    check("safety", int'((|main_lights[1:0]) && (|side_lights[1:0])), 0);
    if (state_out < 3'd7) occ[state_out]++;
  endtask

  task automatic do_reset();
    tick_en = 1'b0; vehicle_detected = 1'b0; flash_r = 1'b0;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    #7;
    check("rst_state", int'(state_out), 5);
    check("rst_main", int'(main_lights), 4);
    check("rst_side", int'(side_lights), 4);
    check("rst_req", int'(req_pending), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) occ[i] = 0;
  endtask

  initial begin
    rst_n = 1'b1; tick_en = 1'b0; vehicle_detected = 1'b0; flash_r = 1'b0;
    model_reset();

    // 1: no demand -> main green held, no request.
    do_reset();
    for (int i = 0; i < 102; i++) step(1'b1, 1'b0, 1'b0);
    check("t1_all_red", occ[5], 1);
    check("t1_main_grn", int'(main_lights), 1);
    check("t1_req", int'(req_pending), 0);

    // 2: vehicle continuously present -> side green capped at max.
    do_reset();
    for (int i = 0; i < 48; i++) step(1'b1, 1'b1, 1'b0);
    check("t2_mg_len", occ[0], MAIN_MIN);
    check("t2_my_len", occ[1], YEL);
    check("t2_sg_len", occ[3], SIDE_MAX);
    check("t2_sy_len", occ[4], YEL);
    check("t2_rearm", int'(req_pending), 1);

    // 3: one-cycle pulse during main green -> latched, side gets minimum.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t3_latched", int'(req_pending), 1);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1'b0);
    check("t3_mg_len", occ[0], MAIN_MIN);
    check("t3_sg_len", occ[3], SIDE_MIN);
    check("t3_end_state", int'(state_out), 5);

    // 4: tick every 4th cycle -> durations scale by 4.
    do_reset();
    for (int i = 0; i < 170; i++) step(((i % 4) == 3), (i == 20), 1'b0);
    check("t4_my_len", occ[1], 4 * YEL);
    check("t4_sg_len", occ[3], 4 * SIDE_MIN);
    check("t4_sy_len", occ[4], 4 * YEL);

    // 5: asynchronous reset in the middle of side green.
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0);
    check("t5_in_sg", int'(state_out), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_state", int'(state_out), 5);
    check("t5_rst_main", int'(main_lights), 4);
    check("t5_rst_side", int'(side_lights), 4);
    check("t5_rst_req", int'(req_pending), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);

`ifdef FLASH_MODE_EN
    // 6: flash request during main green, then release.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("t6_flash_st", int'(state_out), 6);
    check("t6_blink_on", int'(main_lights), 2);
    step(1'b1, 1'b0, 1'b1);
    check("t6_blink_off", int'(main_lights), 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    check("t6_ar2_len", occ[5], ARED + 1);
    check("t6_back_mg", int'(state_out), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
